memory_stage: RTL and testbench

- Pipeline MEM stage of the 5-stage RV32I core.
- Performs loads and stores against an internal byte-enabled data memory and aligns load data to bit 0.
- Holds the MEM/WB pipeline register that feeds the writeback stage: ALUOutW, ReadDataMemW, LUI_or_AUIPCW, PCPlus4W, ResultSrcW, RegWriteW, rdW.
- Also exports MEM-stage forwarding and hazard signals.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/dmem_be.sv | 25 ++
 rtl/memory_stage.sv | 135 +++++++++++++
 tb/tb_memory_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the pipeline stages.
package riscv_pkg;

  localparam logic [2:0] RES_ALU = 3'd0;
  localparam logic [2:0] RES_LUI = 3'd1;
  localparam logic [2:0] RES_LB  = 3'd2;
  localparam logic [2:0] RES_LH  = 3'd3;
  localparam logic [2:0] RES_LW  = 3'd4;
  localparam logic [2:0] RES_LBU = 3'd5;
  localparam logic [2:0] RES_LHU = 3'd6;
  localparam logic [2:0] RES_PC4 = 3'd7;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

endpackage

// File: rtl/dmem_be.sv
// Word-organised data RAM: byte-enabled synchronous write, asynchronous read.
module dmem_be #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic                          clk,
  input  logic [$clog2(DMEM_WORDS)-1:0] i_addr,
  input  logic [3:0]                    i_be,
  input  logic [31:0]                   i_wdata,
  output logic [31:0]                   o_rdata
);

  logic [3:0][7:0] r_mem [DMEM_WORDS];

  // Byte-lane write; lanes with a clear enable keep their contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) begin
        r_mem[i_addr][i] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: data memory access, load lane alignment and the MEM/WB register.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] LUI_or_AUIPCM,
  input  logic [31:0] PCPlus4M,
  input  logic [2:0]  ResultSrcM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  rdM,
  input  logic        FlushW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataMemW,
  output logic [31:0] LUI_or_AUIPCW,
  output logic [31:0] PCPlus4W,
  output logic [2:0]  ResultSrcW,
  output logic        RegWriteW,
  output logic [4:0]  rdW,
  output logic [31:0] ALUOutM2E,
  output logic        RegWriteM2H,
  output logic [4:0]  rdM2H,
  output logic        MisalignM
);

  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [1:0]         w_off;
  logic [DMEM_AW-1:0] w_widx;
  logic               w_is_load;
  logic               w_ld_mis;
  logic               w_st_mis;
  logic               w_st_illegal;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_rword;
  logic [31:0]        w_aligned;
  logic               w_we;

  assign w_off     = ALUOutM[1:0];
  assign w_widx    = ALUOutM[DMEM_AW+1:2];
  assign w_is_load = (ResultSrcM >= RES_LB) && (ResultSrcM <= RES_LHU);

  // Load alignment check by access size
  always_comb begin
    w_ld_mis = 1'b0;
    case (ResultSrcM)
      RES_LH, RES_LHU: w_ld_mis = w_off[0];
      RES_LW:          w_ld_mis = (w_off != 2'b00);
      default:         w_ld_mis = 1'b0;
    endcase
  end

  // Store lane enables and lane-replicated data; a replicated pattern lands in the right lanes
  always_comb begin
    w_be         = 4'b0000;
    w_wdata      = WriteDataM;
    w_st_mis     = 1'b0;
    w_st_illegal = 1'b0;
    case (funct3M)
      F3_SB: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      F3_SH: begin
        w_be     = 4'b0011 << w_off;
        w_wdata  = {2{WriteDataM[15:0]}};
        w_st_mis = w_off[0];
      end
      F3_SW: begin
        w_be     = 4'b1111;
        w_st_mis = (w_off != 2'b00);
      end
      default: begin
        w_st_illegal = 1'b1;
      end
    endcase
  end

  assign MisalignM = (w_is_load & w_ld_mis) | (MemWriteM & (w_st_mis | w_st_illegal));
  // Reset held across the edge must not let a store land
  assign w_we      = MemWriteM & ~MisalignM & ~reset;

  dmem_be #(
    .DMEM_WORDS (DMEM_WORDS)
  ) u_dmem (
    .clk     (clk),
    .i_addr  (w_widx),
    .i_be    (w_we ? w_be : 4'b0000),
    .i_wdata (w_wdata),
    .o_rdata (w_rword)
  );

  assign w_aligned = (ResultSrcM == RES_LW) ? w_rword : (w_rword >> {w_off, 3'b000});

  assign ALUOutM2E   = ALUOutM;
  assign RegWriteM2H = RegWriteM;
  assign rdM2H       = rdM;

  // MEM/WB pipeline register; FlushW turns the slot into a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUOutW       <= 32'h0000_0000;
      ReadDataMemW  <= 32'h0000_0000;
      LUI_or_AUIPCW <= 32'h0000_0000;
      PCPlus4W      <= 32'h0000_0000;
      ResultSrcW    <= 3'd0;
      RegWriteW     <= 1'b0;
      rdW           <= 5'd0;
    end else if (FlushW) begin
      ALUOutW       <= 32'h0000_0000;
      ReadDataMemW  <= 32'h0000_0000;
      LUI_or_AUIPCW <= 32'h0000_0000;
      PCPlus4W      <= 32'h0000_0000;
      ResultSrcW    <= 3'd0;
      RegWriteW     <= 1'b0;
      rdW           <= 5'd0;
    end else begin
      ALUOutW       <= ALUOutM;
      ReadDataMemW  <= w_aligned;
      LUI_or_AUIPCW <= LUI_or_AUIPCM;
      PCPlus4W      <= PCPlus4M;
      ResultSrcW    <= ResultSrcM;
      RegWriteW     <= RegWriteM & ~(w_is_load & MisalignM);
      rdW           <= rdM;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a byte-array reference model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] alu = 32'h0, wd = 32'h0, lui = 32'h0, pc4 = 32'h0;
  logic [2:0]  rs = 3'd0, f3 = 3'd0;
  logic        rw = 1'b0, mw = 1'b0, flush = 1'b0;
  logic [4:0]  rd = 5'd0;

  logic [31:0] alu_w, rdata_w, lui_w, pc4_w, alu_m2e;
  logic [2:0]  rs_w;
  logic        rw_w, rw_m2h, misalign;
  logic [4:0]  rd_w, rd_m2h;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] model_mem [256];

  memory_stage #(.DMEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .ALUOutM(alu), .WriteDataM(wd), .LUI_or_AUIPCM(lui), .PCPlus4M(pc4),
    .ResultSrcM(rs), .RegWriteM(rw), .MemWriteM(mw), .funct3M(f3), .rdM(rd),
    .FlushW(flush),
    .ALUOutW(alu_w), .ReadDataMemW(rdata_w), .LUI_or_AUIPCW(lui_w), .PCPlus4W(pc4_w),
    .ResultSrcW(rs_w), .RegWriteW(rw_w), .rdW(rd_w),
    .ALUOutM2E(alu_m2e), .RegWriteM2H(rw_m2h), .rdM2H(rd_m2h), .MisalignM(misalign)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input logic [2:0] t_rs, input logic t_rw, input logic t_mw,
                        input logic [2:0] t_f3, input logic [31:0] t_alu,
                        input logic [31:0] t_wd, input logic [4:0] t_rd, input logic t_flush);
    rs = t_rs; rw = t_rw; mw = t_mw; f3 = t_f3; alu = t_alu; wd = t_wd; rd = t_rd;
    flush = t_flush;
    lui = $urandom;
    pc4 = $urandom;
  endtask

  task automatic check_w_zero(input string tag);
    check_val({tag, "_alu"}, alu_w, 32'h0);
    check_val({tag, "_rdata"}, rdata_w, 32'h0);
    check_val({tag, "_lui"}, lui_w, 32'h0);
    check_val({tag, "_pc4"}, pc4_w, 32'h0);
    check_val({tag, "_rs"}, {29'h0, rs_w}, 32'h0);
    check_val({tag, "_rw"}, {31'h0, rw_w}, 32'h0);
    check_val({tag, "_rd"}, {27'h0, rd_w}, 32'h0);
  endtask

  // One pipeline slot: predict from the current inputs, clock, compare, then update the model.
  // Addresses used by the bench keep bits [11:8] zero so the 256-byte model covers them.
  task automatic run_cycle();
    int a, base, ld_size, st_size;
    bit is_ld, exp_mis, st_illegal;
    logic [31:0] word, exp_rd, s_alu, s_lui, s_pc4, s_wd;
    logic [2:0] s_rs;
    logic s_rw, s_mw, s_flush;
    logic [4:0] s_rd;
    #1;
    a = int'(alu[7:0]);
    base = a - (a % 4);
    is_ld = (rs >= 3'd2) && (rs <= 3'd6);
    case (rs)
      3'd3, 3'd6: ld_size = 2;
      3'd4:       ld_size = 4;
      default:    ld_size = 1;
    endcase
    st_illegal = 1'b0;
    case (f3)
      3'b000:  st_size = 1;
      3'b001:  st_size = 2;
      3'b010:  st_size = 4;
      default: begin st_size = 1; st_illegal = 1'b1; end
    endcase
    exp_mis = (is_ld && (a % ld_size != 0)) || (mw && (st_illegal || (a % st_size != 0)));
    word = {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
    exp_rd = (rs == 3'd4) ? word : (word >> (8 * (a % 4)));
    s_alu = alu; s_lui = lui; s_pc4 = pc4; s_wd = wd; s_rs = rs; s_rw = rw; s_mw = mw;
    s_flush = flush; s_rd = rd;

    check_val("misalign", {31'h0, misalign}, {31'h0, exp_mis});
    check_val("alu_m2e", alu_m2e, s_alu);
    check_val("rw_m2h", {31'h0, rw_m2h}, {31'h0, s_rw});
    check_val("rd_m2h", {27'h0, rd_m2h}, {27'h0, s_rd});

    @(posedge clk);
    #1;
    if (s_flush) begin
      check_w_zero("flush");
    end else begin
      check_val("alu_w", alu_w, s_alu);
      check_val("lui_w", lui_w, s_lui);
      check_val("pc4_w", pc4_w, s_pc4);
      check_val("rs_w", {29'h0, rs_w}, {29'h0, s_rs});
      check_val("rd_w", {27'h0, rd_w}, {27'h0, s_rd});
      check_val("rw_w", {31'h0, rw_w}, {31'h0, s_rw && !(is_ld && exp_mis)});
      if (is_ld) check_val("rdata_w", rdata_w, exp_rd);
    end
    if (s_mw && !exp_mis) begin
      for (int k = 0; k < st_size; k++) model_mem[a + k] = s_wd[8*k +: 8];
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 check_w_zero("por");
    @(posedge clk); #1 reset = 1'b0;

    // Fill the modelled region so every read has a known value
    for (int i = 0; i < 64; i++) begin
      set_op(3'd0, 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom, 5'd0, 1'b0);
      run_cycle();
    end

    // Asynchronous reset with live W values
    set_op(3'd7, 1'b1, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 5'd9, 1'b0);
    run_cycle();
    check_val("pre_rst_rw", {31'h0, rw_w}, 32'h1);
    reset = 1'b1;
    #1 check_w_zero("async_rst");
    // Store presented while reset is held across the edge must not land
    set_op(3'd0, 1'b0, 1'b1, 3'b010, 32'h30, 32'h5555_5555, 5'd0, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    set_op(3'd4, 1'b1, 1'b0, 3'd0, 32'h30, 32'h0, 5'd1, 1'b0);
    run_cycle();

    // sw then lw of the same word
    set_op(3'd0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0); run_cycle();
    set_op(3'd4, 1'b1, 1'b0, 3'd0, 32'h10, 32'h0, 5'd3, 1'b0); run_cycle();
    check_val("lw_deadbeef", rdata_w, 32'hDEAD_BEEF);
    check_val("lw_rw", {31'h0, rw_w}, 32'h1);

    // sb into lane 3, then lbu and lw
    set_op(3'd0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h1122_3344, 5'd0, 1'b0); run_cycle();
    set_op(3'd0, 1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_00AA, 5'd0, 1'b0); run_cycle();
    set_op(3'd5, 1'b1, 1'b0, 3'd0, 32'h13, 32'h0, 5'd4, 1'b0); run_cycle();
    check_val("lbu_aa", {24'h0, rdata_w[7:0]}, 32'hAA);
    set_op(3'd4, 1'b1, 1'b0, 3'd0, 32'h10, 32'h0, 5'd4, 1'b0); run_cycle();
    check_val("lw_aa2233", rdata_w, 32'hAA22_3344);

    // sh upper half, lh, then a misaligned sh that must not write
    set_op(3'd0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 5'd0, 1'b0); run_cycle();
    set_op(3'd0, 1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 5'd0, 1'b0); run_cycle();
    set_op(3'd3, 1'b1, 1'b0, 3'd0, 32'h22, 32'h0, 5'd6, 1'b0); run_cycle();
    check_val("lh_beef", {16'h0, rdata_w[15:0]}, 32'hBEEF);
    set_op(3'd0, 1'b0, 1'b1, 3'b001, 32'h21, 32'h0000_1234, 5'd0, 1'b0);
    #1 check_val("sh_mis", {31'h0, misalign}, 32'h1);
    run_cycle();
    set_op(3'd4, 1'b1, 1'b0, 3'd0, 32'h20, 32'h0, 5'd6, 1'b0); run_cycle();
    check_val("sh_mis_nowrite", rdata_w, 32'hBEEF_0000);

    // Misaligned lw suppresses the register write; the next aligned one does not
    set_op(3'd4, 1'b1, 1'b0, 3'd0, 32'h06, 32'h0, 5'd7, 1'b0);
    #1 check_val("lw_mis", {31'h0, misalign}, 32'h1);
    run_cycle();
    check_val("lw_mis_rw", {31'h0, rw_w}, 32'h0);
    set_op(3'd4, 1'b1, 1'b0, 3'd0, 32'h04, 32'h0, 5'd7, 1'b0); run_cycle();
    check_val("lw_ok_rw", {31'h0, rw_w}, 32'h1);

    // Flush bubbles W but still lets the store through
    set_op(3'd7, 1'b1, 1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, 5'd5, 1'b1); run_cycle();
    check_val("flush_rw", {31'h0, rw_w}, 32'h0);
    check_val("flush_rd", {27'h0, rd_w}, 32'h0);
    set_op(3'd4, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 5'd8, 1'b0); run_cycle();
    check_val("flush_store", rdata_w, 32'hCAFE_F00D);

    // Random traffic; upper address bits exercise the wrap
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r_f3;
      r_f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      set_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
             r_f3, (($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255))), $urandom,
             5'($urandom_range(0, 31)), ($urandom_range(0, 9) == 0));
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
